// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Package  : keypad_pkg
// Brief    : Key codes, entry-state encoding and 4x4 keypad decode helpers.
// Revision : 1.0
// ============================================================================
package keypad_pkg;

    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_1     = 4'd1;
    localparam logic [3:0] KEY_2     = 4'd2;
    localparam logic [3:0] KEY_3     = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_7     = 4'd7;
    localparam logic [3:0] KEY_8     = 4'd8;
    localparam logic [3:0] KEY_9     = 4'd9;
    localparam logic [3:0] KEY_A     = 4'd10;
    localparam logic [3:0] KEY_B     = 4'd11;
    localparam logic [3:0] KEY_C     = 4'd12;
    localparam logic [3:0] KEY_D     = 4'd13;
    localparam logic [3:0] KEY_CLEAR = 4'd14;
    localparam logic [3:0] KEY_NEXT  = 4'd15;

    typedef enum logic [1:0] {
        DIVIDEND = 2'd0,
        DIVISOR  = 2'd1,
        DONE     = 2'd2
    } entry_state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Only meaningful when both vectors are one-hot.
    function automatic logic [3:0] decode_key(input logic [3:0] row, input logic [3:0] col);
        logic [3:0] code;
        code = KEY_0;
        case ({onehot_index(row), onehot_index(col)})
            4'h0: code = KEY_1;
            4'h1: code = KEY_2;
            4'h2: code = KEY_3;
            4'h3: code = KEY_A;
            4'h4: code = KEY_4;
            4'h5: code = KEY_5;
            4'h6: code = KEY_6;
            4'h7: code = KEY_B;
            4'h8: code = KEY_7;
            4'h9: code = KEY_8;
            4'hA: code = KEY_9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_CLEAR;
            4'hD: code = KEY_0;
            4'hE: code = KEY_NEXT;
            4'hF: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : key_debouncer
// Brief    : Synchronizes keypad lines, decodes and debounces into press events.
// Revision : 1.0
// ============================================================================
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rowk,
    input  logic [3:0] columnk,
    output logic [3:0] key_code,
    output logic       key_evt
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_TARGET = CW'(DEBOUNCE_CYCLES);

    logic [3:0]    r_row_s1, r_row_s2, r_col_s1, r_col_s2;
    logic [3:0]    r_code;
    logic [CW-1:0] r_cnt;
    logic          r_locked;
    logic          r_evt;

    logic          w_valid;
    logic [3:0]    w_code;
    logic [CW-1:0] w_cnt_inc;

    assign w_valid   = is_onehot(r_row_s2) && is_onehot(r_col_s2);
    assign w_code    = decode_key(r_row_s2, r_col_s2);
    // Same code as the running candidate extends the streak, anything else restarts it.
    assign w_cnt_inc = ((r_cnt != '0) && (w_code == r_code)) ? r_cnt + CW'(1) : CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_s1 <= '0;
            r_row_s2 <= '0;
            r_col_s1 <= '0;
            r_col_s2 <= '0;
            r_code   <= '0;
            r_cnt    <= '0;
            r_locked <= 1'b0;
            r_evt    <= 1'b0;
        end else begin
            r_row_s1 <= rowk;
            r_row_s2 <= r_row_s1;
            r_col_s1 <= columnk;
            r_col_s2 <= r_col_s1;
            r_evt    <= 1'b0;
            if (r_locked) begin
                // While locked the counter measures the release streak.
                if (w_valid) begin
                    r_cnt <= '0;
                end else if (r_cnt + CW'(1) == C_TARGET) begin
                    r_cnt    <= '0;
                    r_locked <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else if (!w_valid) begin
                r_cnt <= '0;
            end else begin
                r_code <= w_code;
                if (w_cnt_inc == C_TARGET) begin
                    r_evt    <= 1'b1;
                    r_locked <= 1'b1;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign key_code = r_code;
    assign key_evt  = r_evt;

endmodule
`default_nettype wire

// File: rtl/keypad_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_operand_entry
// Brief    : Keypad operand entry for the divider: digit accumulation and start.
// Revision : 1.0
// ============================================================================
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int W               = 16,
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   rowk,
    input  logic [3:0]   columnk,
    input  logic         equal,
    output logic [W-1:0] dividend,
    output logic [W-1:0] divisor,
    output logic         start,
    output logic         entry_sel,
    output logic         ovf,
    output logic         err_div0
);

    localparam int AW = W + 4;

    logic [3:0]   w_key_code;
    logic         w_key_evt;

    logic         r_eq_s1, r_eq_s2, r_eq_prev, r_eq_evt;

    entry_state_t r_state, w_state_next;
    logic [W-1:0] r_dividend, w_dividend_next;
    logic [W-1:0] r_divisor, w_divisor_next;
    logic         r_start, w_start_next;
    logic         r_ovf, w_ovf_next;
    logic         r_err, w_err_next;

    logic         w_is_digit, w_is_clear, w_is_next;
    logic [W-1:0] w_target;
    logic [AW-1:0] w_acc;
    logic         w_acc_ovf;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk      (clk),
        .rst      (rst),
        .rowk     (rowk),
        .columnk  (columnk),
        .key_code (w_key_code),
        .key_evt  (w_key_evt)
    );

    // The equal edge is registered so start lands exactly one cycle after the event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eq_s1   <= 1'b0;
            r_eq_s2   <= 1'b0;
            r_eq_prev <= 1'b0;
            r_eq_evt  <= 1'b0;
        end else begin
            r_eq_s1   <= equal;
            r_eq_s2   <= r_eq_s1;
            r_eq_prev <= r_eq_s2;
            r_eq_evt  <= r_eq_s2 & ~r_eq_prev;
        end
    end

    assign w_is_digit = w_key_evt && (w_key_code <= KEY_9);
    assign w_is_clear = w_key_evt && (w_key_code == KEY_CLEAR);
    assign w_is_next  = w_key_evt && (w_key_code == KEY_NEXT);
    assign w_target   = (r_state == DIVISOR) ? r_divisor : r_dividend;
    assign w_acc      = {4'b0000, w_target} * AW'(10) + AW'(w_key_code);
    assign w_acc_ovf  = |w_acc[AW-1:W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= DIVIDEND;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_start    <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dividend <= w_dividend_next;
            r_divisor  <= w_divisor_next;
            r_start    <= w_start_next;
            r_ovf      <= w_ovf_next;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_dividend_next = r_dividend;
        w_divisor_next  = r_divisor;
        w_start_next    = 1'b0;
        w_ovf_next      = r_ovf;
        w_err_next      = r_err;

        if (w_is_clear) begin
            w_state_next    = DIVIDEND;
            w_dividend_next = '0;
            w_divisor_next  = '0;
            w_ovf_next      = 1'b0;
            w_err_next      = 1'b0;
        end else if (r_eq_evt && (r_state == DIVISOR)) begin
            if (r_divisor != '0) begin
                w_start_next = 1'b1;
                w_state_next = DONE;
                w_err_next   = 1'b0;
            end else begin
                w_err_next = 1'b1;
            end
        end else if (w_is_digit) begin
            case (r_state)
                DONE: begin
                    w_state_next    = DIVIDEND;
                    w_dividend_next = W'(w_key_code);
                    w_divisor_next  = '0;
                    w_ovf_next      = 1'b0;
                    w_err_next      = 1'b0;
                end
                DIVISOR: begin
                    if (w_acc_ovf) w_ovf_next = 1'b1;
                    else           w_divisor_next = w_acc[W-1:0];
                end
                default: begin
                    if (w_acc_ovf) w_ovf_next = 1'b1;
                    else           w_dividend_next = w_acc[W-1:0];
                end
            endcase
        end else if (w_is_next && (r_state == DIVIDEND)) begin
            w_state_next = DIVISOR;
        end
    end

    assign dividend  = r_dividend;
    assign divisor   = r_divisor;
    assign start     = r_start;
    assign entry_sel = (r_state == DIVISOR);
    assign ovf       = r_ovf;
    assign err_div0  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_operand_entry
// Brief    : Directed self-checking bench for keypad_operand_entry.
// Revision : 1.0
// ============================================================================
module tb_keypad_operand_entry;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   rowk = 4'd0;
    logic [3:0]   columnk = 4'd0;
    logic         equal = 1'b0;
    logic [W-1:0] dividend, divisor;
    logic         start, entry_sel, ovf, err_div0;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;

    keypad_operand_entry #(
        .W               (W),
        .DEBOUNCE_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rowk      (rowk),
        .columnk   (columnk),
        .equal     (equal),
        .dividend  (dividend),
        .divisor   (divisor),
        .start     (start),
        .entry_sel (entry_sel),
        .ovf       (ovf),
        .err_div0  (err_div0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start) start_cnt++;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_rc(input logic [3:0] r, input logic [3:0] c, input int hold);
        @(negedge clk);
        rowk = r;
        columnk = c;
        idle(hold);
        rowk = 4'd0;
        columnk = 4'd0;
        idle(6);
    endtask

    task automatic press_digit(input int d);
        logic [3:0] r, c;
        if (d == 0) begin
            r = 4'b1000;
            c = 4'b0010;
        end else begin
            r = 4'b0001 << ((d - 1) / 3);
            c = 4'b0001 << ((d - 1) % 3);
        end
        press_rc(r, c, 6);
    endtask

    task automatic press_clear();
        press_rc(4'b1000, 4'b0001, 6);
    endtask

    task automatic press_next();
        press_rc(4'b1000, 4'b0100, 6);
    endtask

    task automatic press_equal();
        @(negedge clk);
        equal = 1'b1;
        idle(8);
        equal = 1'b0;
        idle(4);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        idle(3);
        checks++;
        if ({dividend, divisor, start, entry_sel, ovf, err_div0} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %0d/%0d s=%0b sel=%0b ovf=%0b e=%0b expected all 0",
                     dividend, divisor, start, entry_sel, ovf, err_div0);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        int seen, at_idx;
        logic [W-1:0] d_at, v_at;
        seen = 0;
        at_idx = -1;
        d_at = '0;
        v_at = '0;
        press_digit(1);
        press_digit(2);
        checks++;
        if (dividend !== 16'd12 || entry_sel !== 1'b0) begin
            failures++;
            $display("FAIL basic_dividend: got %0d sel=%0b expected 12 sel=0", dividend, entry_sel);
        end
        press_next();
        checks++;
        if (entry_sel !== 1'b1) begin
            failures++;
            $display("FAIL basic_next_sel: got %0b expected 1", entry_sel);
        end
        press_digit(4);
        checks++;
        if (divisor !== 16'd4) begin
            failures++;
            $display("FAIL basic_divisor: got %0d expected 4", divisor);
        end
        @(negedge clk);
        equal = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (start === 1'b1) begin
                seen++;
                if (at_idx < 0) begin
                    at_idx = i;
                    d_at = dividend;
                    v_at = divisor;
                end
            end
        end
        equal = 1'b0;
        checks++;
        if (seen !== 1) begin
            failures++;
            $display("FAIL basic_start_width: got %0d cycles expected 1", seen);
        end
        checks++;
        if (at_idx !== 4) begin
            failures++;
            $display("FAIL basic_start_latency: got cycle %0d expected 4", at_idx);
        end
        checks++;
        if (d_at !== 16'd12 || v_at !== 16'd4) begin
            failures++;
            $display("FAIL basic_operands_at_start: got %0d/%0d expected 12/4", d_at, v_at);
        end
        idle(4);
        checks++;
        if (entry_sel !== 1'b0 || dividend !== 16'd12 || divisor !== 16'd4) begin
            failures++;
            $display("FAIL basic_done_hold: got %0d/%0d sel=%0b expected 12/4 sel=0",
                     dividend, divisor, entry_sel);
        end
    endtask

    task automatic test_overflow();
        press_clear();
        press_digit(6);
        press_digit(5);
        press_digit(5);
        press_digit(3);
        press_digit(5);
        checks++;
        if (dividend !== 16'd65535 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_max: got %0d ovf=%0b expected 65535 ovf=0", dividend, ovf);
        end
        press_digit(0);
        checks++;
        if (dividend !== 16'd65535 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop: got %0d ovf=%0b expected 65535 ovf=1", dividend, ovf);
        end
        press_clear();
        checks++;
        if (dividend !== 16'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got %0d ovf=%0b expected 0 ovf=0", dividend, ovf);
        end
    endtask

    task automatic test_div0();
        int s0;
        press_digit(7);
        press_next();
        press_digit(0);
        s0 = start_cnt;
        press_equal();
        checks++;
        if (start_cnt !== s0 || err_div0 !== 1'b1 || entry_sel !== 1'b1) begin
            failures++;
            $display("FAIL div0_flag: got starts=%0d err=%0b sel=%0b expected starts=%0d err=1 sel=1",
                     start_cnt, err_div0, entry_sel, s0);
        end
        press_digit(3);
        press_equal();
        checks++;
        if (start_cnt !== s0 + 1 || err_div0 !== 1'b0) begin
            failures++;
            $display("FAIL div0_recover: got starts=%0d err=%0b expected starts=%0d err=0",
                     start_cnt, err_div0, s0 + 1);
        end
        checks++;
        if (dividend !== 16'd7 || divisor !== 16'd3 || entry_sel !== 1'b0) begin
            failures++;
            $display("FAIL div0_operands: got %0d/%0d sel=%0b expected 7/3 sel=0",
                     dividend, divisor, entry_sel);
        end
    endtask

    task automatic test_bounce();
        press_clear();
        @(negedge clk);
        rowk = 4'b0010;
        columnk = 4'b0010;
        @(negedge clk);
        rowk = 4'd0;
        columnk = 4'd0;
        idle(8);
        checks++;
        if (dividend !== 16'd0) begin
            failures++;
            $display("FAIL bounce_glitch: got %0d expected 0", dividend);
        end
        press_rc(4'b0010, 4'b0010, 100);
        checks++;
        if (dividend !== 16'd5) begin
            failures++;
            $display("FAIL bounce_hold: got %0d expected 5", dividend);
        end
        press_rc(4'b0011, 4'b0001, 10);
        checks++;
        if (dividend !== 16'd5 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL bounce_multihot: got %0d ovf=%0b expected 5 ovf=0", dividend, ovf);
        end
    endtask

    task automatic test_reentry();
        press_clear();
        press_digit(1);
        press_digit(2);
        press_next();
        press_digit(4);
        press_equal();
        press_digit(9);
        checks++;
        if (dividend !== 16'd9 || divisor !== 16'd0 || entry_sel !== 1'b0) begin
            failures++;
            $display("FAIL reentry_digit: got %0d/%0d sel=%0b expected 9/0 sel=0",
                     dividend, divisor, entry_sel);
        end
        press_digit(3);
        checks++;
        if (dividend !== 16'd93) begin
            failures++;
            $display("FAIL reentry_second: got %0d expected 93", dividend);
        end
        @(negedge clk);
        rowk = 4'b0001;
        columnk = 4'b0001;
        idle(2);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dividend, divisor, start, entry_sel, ovf, err_div0} !== '0) begin
            failures++;
            $display("FAIL async_reset: got %0d/%0d s=%0b sel=%0b expected all 0",
                     dividend, divisor, start, entry_sel);
        end
        rowk = 4'd0;
        columnk = 4'd0;
        idle(2);
        rst = 1'b0;
        idle(6);
        checks++;
        if (dividend !== 16'd0 || entry_sel !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got %0d sel=%0b expected 0 sel=0", dividend, entry_sel);
        end
    endtask

    task automatic test_simultaneous();
        int s0;
        press_digit(1);
        press_next();
        press_digit(4);
        s0 = start_cnt;
        @(negedge clk);
        rowk = 4'b1000;
        columnk = 4'b0001;
        @(negedge clk);
        equal = 1'b1;
        idle(8);
        equal = 1'b0;
        rowk = 4'd0;
        columnk = 4'd0;
        idle(8);
        checks++;
        if (start_cnt !== s0) begin
            failures++;
            $display("FAIL simul_no_start: got %0d starts expected %0d", start_cnt, s0);
        end
        checks++;
        if (dividend !== 16'd0 || divisor !== 16'd0 || entry_sel !== 1'b0) begin
            failures++;
            $display("FAIL simul_clear: got %0d/%0d sel=%0b expected 0/0 sel=0",
                     dividend, divisor, entry_sel);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_div0();
        test_bounce();
        test_reentry();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_operand_entry.md
# keypad_operand_entry

Front-end stage feeding the divider: samples the 4×4 keypad row/column lines and the `equal` button, then debounces and decodes key presses. Accumulates decimal digits into a dividend and a divisor and issues a one-cycle `start` pulse once both operands are complete. While idle after a start, it holds both operands stable for the downstream divider.

## Interface
- `W`, 16: operand width in bits.
- `DEBOUNCE_CYCLES`, 2: consecutive identical valid samples required to accept a key. Boards use about 500000.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rowk`  in  4: keypad row lines, one-hot; bit i = row i. Asynchronous to `clk`.
- `columnk`  in  4: keypad column lines, one-hot; bit j = column j. Asynchronous to `clk`.
- `equal`  in  1: "compute" button, level. Asynchronous to `clk`.
- `dividend`  out  W: first operand, unsigned binary.
- `divisor`  out  W: second operand, unsigned binary.
- `start`  out  1: one-cycle pulse; operands are valid in that cycle.
- `entry_sel`  out  1: 0 = digits go to the dividend; 1 = digits go to the divisor.
- `ovf`  out  1: sticky; a digit was dropped because it would exceed 2^W−1.
- `err_div0`  out  1: sticky; `equal` was pressed while the divisor was 0.

## Operation
- Key map, row 0..3 by column 0..3:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D
- Key functions: `*` = CLEAR, `#` = NEXT. Keys A–D decode but are ignored.
- Input conditioning:
  - `rowk`, `columnk` and `equal` each pass through a 2-flop synchronizer.
  - A sample is a valid key only if both vectors are exactly one-hot. Zero or multi-hot counts as no key.
- Debounce:
  - A counter tracks consecutive cycles of the same valid code.
  - The cycle the count reaches `DEBOUNCE_CYCLES` produces a single press event.
  - No further event is produced until the synchronized inputs read no-key for `DEBOUNCE_CYCLES` consecutive cycles.
  - A code change before acceptance restarts the count.
- `equal` produces an event on the rising edge of its synchronized value. It is not debounced.
- States:
  - DIVIDEND: reset state; `entry_sel`=0.
  - DIVISOR: `entry_sel`=1.
  - DONE: `entry_sel`=0, operands held.
- Digit d:
  - Target ← target×10 + d, computed at W+4 bits.
  - If the result exceeds 2^W−1, the target is unchanged and `ovf` is set.
  - In DONE, a digit zeroes both operands and clears both flags, sets dividend=d, and moves to DIVIDEND.
- NEXT: DIVIDEND → DIVISOR. Ignored in DIVISOR and in DONE.
- equal:
  - In DIVISOR with divisor≠0: pulse `start`, go to DONE, clear `err_div0`.
  - In DIVISOR with divisor=0: set `err_div0`, no start, stay in DIVISOR.
  - Ignored in DIVIDEND and DONE.
- CLEAR (any state): zero both operands, clear `ovf` and `err_div0`, go to DIVIDEND.
- Same-cycle priority: CLEAR > equal > digit/NEXT. The lower-priority event is discarded, not deferred.

## Timing
- Reset values: all outputs 0; state DIVIDEND; synchronizers and counters 0.
- Asserting `rst` mid-entry or in DONE returns everything to reset values immediately, without waiting for a clock edge.
- Let edge 0 be the first rising edge that samples a settled key. The press event is internal in the cycle after edge DEBOUNCE_CYCLES+1. The operand and `entry_sel` update on edge DEBOUNCE_CYCLES+2.
- Let edge 0 be the first rising edge that samples `equal`=1. `start` is high for exactly the cycle after edge 3.
- `start` never lasts more than one cycle. `dividend` and `divisor` do not change in the `start` cycle or while in DONE.
- A key held indefinitely yields exactly one event.

## Structure
- Package `keypad_pkg` contains:
  - 4-bit key-code constants: KEY_0..KEY_9, KEY_CLEAR, KEY_NEXT, KEY_A..KEY_D.
  - The state encoding: DIVIDEND, DIVISOR, DONE.
  - The row/column → code decode function.
- Sub-module `key_debouncer` (parameter `DEBOUNCE_CYCLES`) covers synchronizer, one-hot validity check, decode, counter and release lock-out. It outputs `key_code[3:0]` and `key_evt`.
- Top level contains the FSM, the ×10+d accumulators, the `equal` edge detector and the flags.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=2 and hold each key for 2 cycles or more, with release of 2 cycles or more.
- Basic entry: 1, 2, #, 4, then `equal` → `dividend`=12, `divisor`=4. `entry_sel` 0→1→0. One `start` pulse exactly 3 cycles after `equal` rises.
- Overflow: 6,5,5,3,5 → `dividend`=65535. Then 0 → `dividend` stays 65535, `ovf`=1. Then `*` → `dividend`=0, `ovf`=0.
- Divide by zero: 7, #, 0, `equal` → no `start`, `err_div0`=1, `entry_sel`=1. Then 3 and `equal` → `divisor`=3, one `start`, `err_div0`=0.
- Bounce and hold:
  - Key `5` valid for 1 cycle → no change.
  - `5` held 100 cycles → `dividend` gains exactly one digit.
  - `rowk`=0011 with `columnk`=0001 → ignored.
- Re-entry and reset: after DONE (12/4), key 9 → `dividend`=9, `divisor`=0, `entry_sel`=0. Then `rst` pulsed mid-entry → all outputs 0.
- Simultaneous events: `*` press event in the same cycle as the `equal` edge, while in DIVISOR with divisor 4 → no `start`, operands 0, state DIVIDEND.
